// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: runs a WIDTH-bit add/sub through an external 4-bit adder slice, one nibble per clock
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [IW+1:0]    shamt;
    logic             run;
    logic             c_msb;

    // Bit offset of the active nibble and the carry into the result MSB on the final pass.
    assign shamt = {idx_q, 2'b00};
    assign run   = (state_q == RUN);
    assign c_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[3];

    // Slice is fed only from registers, and held at zero outside RUN.
    assign slice_a   = run ? 4'(a_q >> shamt) : 4'h0;
    assign slice_b   = run ? 4'(b_q >> shamt) : 4'h0;
    assign slice_cin = run & carry_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Next-state: capture on accept, one nibble per RUN cycle, latch flags on the last pass.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = (res_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(slice_sum) << shamt);
                carry_d = slice_cout;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cout ^ c_msb;
                    zero_d  = (res_d == '0);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer: directed checks of the nibble sequencer against an ideal 4-bit adder slice
module tb_nibble_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        cout, ovf, zero;
    logic [3:0]  slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_cout;
    int          checks = 0;
    int          fails = 0;

    nibble_add_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ovf(ovf), .zero(zero), .slice_a(slice_a), .slice_b(slice_b),
        .slice_cin(slice_cin), .slice_sum(slice_sum), .slice_cout(slice_cout)
    );

    // Ideal combinational adder slice.
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, check per-pass carry-in and final outputs; leaves DUT in DONE.
    task automatic run_op(input string tag, input logic o, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] er, input logic ec, input logic eo, input logic ez,
                          input logic [3:0] ecin);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op = ~o; a = 16'hFFFF; b = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " run out_valid"}, 32'(out_valid), 32'd0);
            chk({tag, " run in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " slice_cin"}, 32'(slice_cin), 32'(ecin[i]));
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " cout"}, 32'(cout), 32'(ec));
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
    endtask

    // Complete the output handshake while offering a request that must be ignored.
    task automatic finish_op(input string tag);
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h1111; op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk("reset slice", {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add1", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 4'b1110);
        finish_op("add1");
        run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 4'b1110);
        finish_op("add_ovf");
        run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b1110);
        finish_op("add_wrap");
        run_op("sub_eq", 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b1111);
        finish_op("sub_eq");
        run_op("sub_borrow", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0001);
        finish_op("sub_borrow");
        run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4'b0001);
        finish_op("sub_ovf");

        run_op("bp", 1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = 16'hABCD; b = 16'h1357;
            @(posedge clk);
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp result", 32'(result), 32'h0303);
            chk("bp flags", {29'd0, cout, ovf, zero}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp");
        run_op("after_bp", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 4'b1110);
        finish_op("after_bp");

        in_valid = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0FFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid partial result", 32'(result), 32'h0033);
        chk("mid slice_cin", 32'(slice_cin), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst result", 32'(result), 32'd0);
        chk("mid rst flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk("mid rst slice", {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 4'b0000);
        finish_op("post_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
- Multi-cycle controller that runs a WIDTH-bit add or subtract through one shared 4-bit carry-lookahead adder slice, one nibble per cycle, starting at the least significant nibble.
- Sits between the ALU operand/opcode stage and the slice. It owns operand capture, nibble sequencing, the carry chain between nibbles, result assembly and status flags.
- The slice itself stays external and combinational. This block only drives its inputs and samples its outputs.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived number of nibble passes. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operation
- op  input  1  0 = add, 1 = subtract (a - b)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum or difference
- cout  output  1  final carry-out (subtract: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  result == 0
- slice_a  output  4  nibble of A to the adder slice
- slice_b  output  4  nibble of B, or of ~B when subtracting, to the slice
- slice_cin  output  1  carry into the slice
- slice_sum  input  4  slice sum
- slice_cout  input  1  slice carry-out

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-RUN):
  - state = IDLE; idx, carry, operand registers, result, cout, ovf and zero all clear to 0.
  - out_valid = 0, in_ready = 1.
  - An in-flight operation is discarded; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0, slice_a/slice_b/slice_cin driven 0.
  - On in_valid & in_ready: capture a and op; capture b as ~b when op = 1, else b.
  - On the same accept: carry <= op, idx <= 0, result <= 0, go to RUN.
- RUN (in_ready = 0, out_valid = 0):
  - Slice inputs are combinational from registers: slice_a = a_reg[4*idx+3:4*idx], slice_b = b_reg[4*idx+3:4*idx], slice_cin = carry.
  - Each clock: result[4*idx+3:4*idx] <= slice_sum; carry <= slice_cout.
  - When idx = NIB-1, go to DONE; otherwise idx <= idx+1. idx never wraps past NIB-1.
- Entering DONE, the block latches the flags:
  - cout <= slice_cout of the last pass.
  - ovf <= slice_cout XOR c_msb, where c_msb = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_sum[3] (carry into the MSB).
  - zero <= 1 when the completed result (including the last nibble) is all zeros.
- DONE:
  - out_valid = 1, in_ready = 0. result and flags stay stable until the handshake completes.
  - On out_ready: go to IDLE. No new operation is accepted in that same cycle (minimum one IDLE cycle between operations).
  - out_ready low holds DONE indefinitely.
- Latency: accept at clock edge k; out_valid is high after edge k+NIB. Throughput is one operation per NIB+2 cycles at most.
- Inputs a, b and op are sampled only on the accept edge. Later changes have no effect.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH. Subtraction is implemented as a + ~b + 1; the +1 comes from the initial carry = op.
- slice_* outputs are purely combinational from registered state. There is no combinational path from any input port to any output port.

Test Plan (WIDTH = 16, slice modelled as an ideal 4-bit adder):
- add 0x1234 + 0x0FFF -> result 0x2233, cout 0, ovf 0, zero 0; out_valid exactly 4 cycles after the accept edge; slice_cin sequence 0, 1, 1, 1.
- add 0x7FFF + 0x0001 -> result 0x8000, ovf 1, cout 0. Also add 0xFFFF + 0x0001 -> result 0x0000, cout 1, ovf 0, zero 1.
- sub 0x0005 - 0x0005 -> result 0x0000, cout 1, zero 1, ovf 0. Also sub 0x0000 - 0x0001 -> result 0xFFFF, cout 0, ovf 0. Also sub 0x8000 - 0x0001 -> result 0x7FFF, ovf 1.
- Backpressure: hold out_ready low for 10 cycles after out_valid -> result, flags and out_valid stable, in_ready 0, in_valid pulses ignored. Then out_ready high -> one IDLE cycle, then the next request is accepted.
- Operand change after accept: accept 0x0101 + 0x0202, then drive a/b to 0xFFFF during RUN -> result 0x0303.
- Reset mid-RUN: assert rst_n low at idx = 2 -> all outputs zero and in_ready 1 immediately (asynchronous). After release, a fresh 0x0001 + 0x0001 returns 0x0002 with correct flags.
